control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute/writeback sequencer directly upstream of ALU_J.
//  - Fetches 16-bit instructions; holds the 8x8 register file and the latched status register.
//  - Drives ALU_J opcode, operands and param; writes result back; resolves GOTO/IF* branches.
// PARAMETERS
//  DataWidth      8   register / ALU data width
//  NumRegs        8   register file depth (3-bit index)
//  PcBits         8   program counter / imem address width
//  InstrBits      16  instruction width
//  NumStatusBits  6   status width, same bit map as ALU_J: 0 C, 1 UF, 2 Z, 3 EQ, 4 GT, 5 ST
// PORTS
//  clock         in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high
//  run           in   1   1 = sequencer may leave FETCH; 0 = hold in FETCH
//  imem_addr     out  8   instruction address (= pc)
//  imem_data     in   16  instruction word, valid 1 cycle after imem_addr (synchronous ROM)
//  alu_opcode    out  5   to ALU_J opcode
//  alu_operand1  out  8   to ALU_J operand1
//  alu_operand2  out  8   to ALU_J operand2
//  alu_param     out  8   to ALU_J param
//  alu_result    in   8   from ALU_J result
//  alu_status    in   6   from ALU_J status
//  pc            out  8   current program counter
//  status_reg    out  6   latched flags
//  state         out  2   FSM state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK
// BEHAVIOUR
//  Reset: pc=0, status_reg=0, all regs=0, state=FETCH, instr=0, alu_* outputs=0.
//  Reset mid-instruction aborts it; nothing is committed.
//  Instr fields: op=[15:11], ra=[10:8], rb=[7:5], imm=[7:0].
//  FSM, 4 cycles per instruction:
//  - FETCH -> DECODE when run=1 (else stay).
//  - DECODE: latch imem_data into instr.
//  - EXECUTE: drive ALU, then capture alu_result/alu_status.
//  - WRITEBACK: commit, then -> FETCH.
//  ALU drive, EXECUTE only:
//  - alu_operand1=R[ra], alu_operand2=R[rb], alu_param=imm.
//  - Opcode = op for 0x01-0x08; CMP (0x0A) issues 0x02 (SUB); all other ops issue 0x00.
//  - Outside EXECUTE all alu_* = 0 (ALU_J NOP).
//  WRITEBACK by op:
//  - 0x01-0x08: R[ra]<=result; status_reg<=captured status.
//  - 0x09 VAL: R[ra]<=imm; status unchanged.
//  - 0x0A CMP: status_reg<=captured status; no register write.
//  - 0x10 GOTO: pc<=imm.
//  - 0x11 IFZ / 0x12 IFNZ / 0x13 IFEQ / 0x14 IFST / 0x15 IFGT: pc<=imm if Z / !Z / EQ / ST / GT,
//    using status_reg as held before this instruction; else pc+1.
//  - 0x00, 0x0B-0x0F, 0x16-0x1F: no effect.
//  - Every non-taken / non-branch instruction: pc<=pc+1, mod 256 (0xFF -> 0x00).
//  Branch to own address (GOTO pc) is legal and loops forever.
//  run deasserted mid-instruction: current instruction completes; the sequencer then holds in FETCH.
//  R[ra] read in EXECUTE sees the write from the previous WRITEBACK (no hazard; strictly serial).
// CONFIGURATION
//  SEQ_STEP_EN defined:
//  - Adds input 'step'. After each WRITEBACK the FSM holds in FETCH until a step rising edge
//    (registered compare) with run=1; one instruction executes per step pulse.
//  - step held high executes exactly one instruction.
//  SEQ_STEP_EN undefined: no step port; free-running whenever run=1.
// TESTING
//  1 reset mid-EXECUTE -> next cycle pc=0, state=0, status_reg=0, no register changed.
//  2 VAL R1,0x05; VAL R2,0x05; CMP R1,R2
//    -> status_reg=6'b001100 (Z,EQ), R1=0x05 unchanged, pc=3 after 12 cycles.
//  3 VAL R1,0xFF; VAL R2,0x01; ADD R1,R2 -> R1=0x00, status_reg[0]=1 and [2]=1.
//  4 After test 2, IFEQ 0x40 -> pc=0x40; after ADD 0x01+0x01, IFZ 0x40 -> pc=next+1.
//  5 pc=0xFF with NOP -> pc wraps to 0x00; run=0 -> state stays 0, pc frozen.
//  6 SEQ_STEP_EN: run=1, three step pulses -> exactly 3 instructions retire, pc=3.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: 4-cycle fetch/decode/execute/writeback sequencer driving ALU_J.
// Optional single-step gating is enabled by defining SEQ_STEP_EN.
module control_sequencer #(
    parameter int DataWidth     = 8,
    parameter int NumRegs       = 8,
    parameter int PcBits        = 8,
    parameter int InstrBits     = 16,
    parameter int NumStatusBits = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
`ifdef SEQ_STEP_EN
    input  logic                     step,
`endif
    output logic [PcBits-1:0]        imem_addr,
    input  logic [InstrBits-1:0]     imem_data,
    output logic [4:0]               alu_opcode,
    output logic [DataWidth-1:0]     alu_operand1,
    output logic [DataWidth-1:0]     alu_operand2,
    output logic [DataWidth-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic [PcBits-1:0]        pc,
    output logic [NumStatusBits-1:0] status_reg,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [PcBits-1:0] PcOne = PcBits'(1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DataWidth-1:0]       r_regs [NumRegs];
    logic [InstrBits-1:0]       r_instr;
    logic [PcBits-1:0]          r_pc;
    logic [NumStatusBits-1:0]   r_status;
    logic [NumStatusBits-1:0]   r_alu_stat;
    logic [DataWidth-1:0]       r_result;
    logic [4:0]                 r_alu_opcode;
    logic [DataWidth-1:0]       r_alu_op1;
    logic [DataWidth-1:0]       r_alu_op2;
    logic [DataWidth-1:0]       r_alu_param;
    logic                       w_leave_fetch;
    logic                       w_taken;
    logic [PcBits-1:0]          w_pc_nxt;

    wire logic [4:0]           w_dec_op  = imem_data[15:11];
    wire logic [2:0]           w_dec_ra  = imem_data[10:8];
    wire logic [2:0]           w_dec_rb  = imem_data[7:5];
    wire logic [DataWidth-1:0] w_dec_imm = imem_data[7:0];
    wire logic [4:0]           w_op      = r_instr[15:11];
    wire logic [2:0]           w_ra      = r_instr[10:8];
    wire logic [DataWidth-1:0] w_imm     = r_instr[7:0];

    // CMP is issued to the ALU as SUB; anything outside the ALU range becomes a NOP.
    function automatic logic [4:0] issue_op(input logic [4:0] op);
        logic [4:0] v;
        if ((op >= 5'h01) && (op <= 5'h08)) begin
            v = op;
        end else if (op == 5'h0A) begin
            v = 5'h02;
        end else begin
            v = 5'h00;
        end
        return v;
    endfunction

`ifdef SEQ_STEP_EN
    logic r_step_d;
    logic r_step_pend;
    wire logic w_step_go = (step & ~r_step_d) | r_step_pend;

    assign w_leave_fetch = run & w_step_go;

    // Step edge detector; a pulse seen mid-instruction stays pending for the next FETCH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_step_d    <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            r_step_d    <= step;
            r_step_pend <= w_step_go & ~((r_state == S_FETCH) & run);
        end
    end
`else
    assign w_leave_fetch = run;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_leave_fetch) begin
                    w_state_nxt = S_DECODE;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DECODE:    w_state_nxt = S_EXECUTE;
            S_EXECUTE:   w_state_nxt = S_WRITEBACK;
            S_WRITEBACK: w_state_nxt = S_FETCH;
            default:     w_state_nxt = S_FETCH;
        endcase
    end

    // Branch resolution against the status held before this instruction.
    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            5'h10:   w_taken = 1'b1;
            5'h11:   w_taken = r_status[2];
            5'h12:   w_taken = ~r_status[2];
            5'h13:   w_taken = r_status[3];
            5'h14:   w_taken = r_status[5];
            5'h15:   w_taken = r_status[4];
            default: w_taken = 1'b0;
        endcase
        if (w_taken) begin
            w_pc_nxt = PcBits'(w_imm);
        end else begin
            w_pc_nxt = r_pc + PcOne;
        end
    end

    // Datapath: ALU drive is registered so it is valid exactly during EXECUTE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
            r_instr      <= '0;
            r_pc         <= '0;
            r_status     <= '0;
            r_alu_stat   <= '0;
            r_result     <= '0;
            r_alu_opcode <= 5'h00;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_param  <= '0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    r_instr      <= imem_data;
                    r_alu_opcode <= issue_op(w_dec_op);
                    r_alu_op1    <= r_regs[w_dec_ra];
                    r_alu_op2    <= r_regs[w_dec_rb];
                    r_alu_param  <= w_dec_imm;
                end
                S_EXECUTE: begin
                    r_result     <= alu_result;
                    r_alu_stat   <= alu_status;
                    r_alu_opcode <= 5'h00;
                    r_alu_op1    <= '0;
                    r_alu_op2    <= '0;
                    r_alu_param  <= '0;
                end
                S_WRITEBACK: begin
                    r_pc <= w_pc_nxt;
                    if ((w_op >= 5'h01) && (w_op <= 5'h08)) begin
                        r_regs[w_ra] <= r_result;
                        r_status     <= r_alu_stat;
                    end else if (w_op == 5'h09) begin
                        r_regs[w_ra] <= w_imm;
                    end else if (w_op == 5'h0A) begin
                        r_status     <= r_alu_stat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign status_reg   = r_status;
    assign state        = r_state;
    assign alu_opcode   = r_alu_opcode;
    assign alu_operand1 = r_alu_op1;
    assign alu_operand2 = r_alu_op2;
    assign alu_param    = r_alu_param;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random programs checked against an instruction-level model.
// Build with SEQ_STEP_EN defined to exercise the single-step gating.
module tb_control_sequencer;

    logic        clock;
    logic        reset;
    logic        run;
`ifdef SEQ_STEP_EN
    logic        step;
    bit          step_keep;
`endif
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [4:0]  alu_opcode;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [7:0]  alu_param;
    logic [7:0]  alu_result;
    logic [5:0]  alu_status;
    logic [7:0]  pc;
    logic [5:0]  status_reg;
    logic [1:0]  state;

    int n_pass;
    int n_fail;
    int n_checks;

    logic [15:0] imem [256];
    logic [7:0]  m_regs [8];
    logic [7:0]  m_pc;
    logic [5:0]  m_st;

    control_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
`ifdef SEQ_STEP_EN
        .step         (step),
`endif
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_param    (alu_param),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .pc           (pc),
        .status_reg   (status_reg),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) imem_data <= imem[imem_addr];

    // Stand-in ALU: status = {ST, GT, EQ, Z, UF, C}.
    function automatic logic [13:0] alu_fn(input logic [4:0] opc, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] p);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       uf;
        c  = 1'b0;
        uf = 1'b0;
        s  = 9'd0;
        case (opc)
            5'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            5'd2: begin r = a - b; uf = (a < b); end
            default: begin r = a ^ b ^ p ^ {3'b000, opc}; c = r[0]; end
        endcase
        return {r[7] & (opc != 5'd2), a > b, a == b, r == 8'd0, uf, c, r};
    endfunction

    assign {alu_status, alu_result} = alu_fn(alu_opcode, alu_operand1, alu_operand2, alu_param);

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] ra, input logic [7:0] imm);
        return {op, ra, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pc = 8'h00;
        m_st = 6'h00;
    endtask

    // Runs one instruction from FETCH and checks every phase against the model.
    task automatic exec_one(input bit drop_run);
        logic [15:0] w;
        logic [4:0]  op;
        logic [4:0]  opc;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [7:0]  imm;
        logic [13:0] ar;
        bit          taken;
        w   = imem[m_pc];
        op  = w[15:11];
        ra  = w[10:8];
        rb  = w[7:5];
        imm = w[7:0];
        if (op >= 5'd1 && op <= 5'd8) opc = op;
        else if (op == 5'h0A)         opc = 5'd2;
        else                          opc = 5'd0;
        ar  = alu_fn(opc, m_regs[ra], m_regs[rb], imm);
        run = 1'b1;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        @(posedge clock); @(negedge clock);
        chk("decode_state", 16'(state), 16'd1);
        if (drop_run) run = 1'b0;
`ifdef SEQ_STEP_EN
        step = step_keep;
`endif
        @(posedge clock); @(negedge clock);
        chk("exec_state", 16'(state), 16'd2);
        chk("exec_opcode", 16'(alu_opcode), 16'(opc));
        chk("exec_op1", 16'(alu_operand1), 16'(m_regs[ra]));
        chk("exec_op2", 16'(alu_operand2), 16'(m_regs[rb]));
        chk("exec_param", 16'(alu_param), 16'(imm));
        @(posedge clock); @(negedge clock);
        chk("wb_state", 16'(state), 16'd3);
        chk("wb_alu_nop", {alu_opcode, 3'b000, alu_param}, 16'h0000);
        taken = 1'b0;
        if (op >= 5'd1 && op <= 5'd8) begin
            m_regs[ra] = ar[7:0];
            m_st       = ar[13:8];
        end else if (op == 5'h09) begin
            m_regs[ra] = imm;
        end else if (op == 5'h0A) begin
            m_st = ar[13:8];
        end else if (op == 5'h10) taken = 1'b1;
        else if (op == 5'h11) taken = m_st[2];
        else if (op == 5'h12) taken = !m_st[2];
        else if (op == 5'h13) taken = m_st[3];
        else if (op == 5'h14) taken = m_st[5];
        else if (op == 5'h15) taken = m_st[4];
        m_pc = taken ? imm : m_pc + 8'd1;
        @(posedge clock); @(negedge clock);
        chk("retire_state", 16'(state), 16'd0);
        chk("retire_pc", 16'(pc), 16'(m_pc));
        chk("retire_addr", 16'(imem_addr), 16'(m_pc));
        chk("retire_status", 16'(status_reg), 16'(m_st));
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_checks = 0;
        run = 1'b0;
        reset = 1'b1;
`ifdef SEQ_STEP_EN
        step = 1'b0;
        step_keep = 1'b0;
`endif
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[8'h00] = enc(5'h09, 3'd1, 8'h05);
        imem[8'h01] = enc(5'h09, 3'd2, 8'h05);
        imem[8'h02] = enc(5'h0A, 3'd1, {3'd2, 5'd0});
        imem[8'h03] = enc(5'h13, 3'd0, 8'h40);
        imem[8'h40] = enc(5'h09, 3'd1, 8'hFF);
        imem[8'h41] = enc(5'h09, 3'd2, 8'h01);
        imem[8'h42] = enc(5'h01, 3'd1, {3'd2, 5'd0});
        imem[8'h43] = enc(5'h09, 3'd1, 8'h01);
        imem[8'h44] = enc(5'h09, 3'd2, 8'h01);
        imem[8'h45] = enc(5'h01, 3'd1, {3'd2, 5'd0});
        imem[8'h46] = enc(5'h11, 3'd0, 8'h40);
        imem[8'h47] = enc(5'h01, 3'd1, {3'd1, 5'd0});
        imem[8'h48] = enc(5'h10, 3'd0, 8'hFF);
        imem[8'hFF] = 16'h0000;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_pc", 16'(pc), 16'd0);
        chk("rst_status", 16'(status_reg), 16'd0);
        chk("rst_alu", {alu_opcode, 3'b000, alu_operand1}, 16'h0000);
        chk("rst_alu2", {alu_operand2, alu_param}, 16'h0000);
        repeat (3) begin
            @(negedge clock);
            chk("idle_state", 16'(state), 16'd0);
        end

        // Abort an instruction in EXECUTE with an asynchronous reset.
        run = 1'b1;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        @(posedge clock); @(posedge clock); @(negedge clock);
        chk("abort_pre_state", 16'(state), 16'd2);
        reset = 1'b1;
        run = 1'b0;
`ifdef SEQ_STEP_EN
        step = 1'b0;
`endif
        #1;
        chk("abort_state", 16'(state), 16'd0);
        chk("abort_pc", 16'(pc), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk("abort_after_state", 16'(state), 16'd0);
        chk("abort_after_pc", 16'(pc), 16'd0);
        chk("abort_after_status", 16'(status_reg), 16'd0);

        // VAL/VAL/CMP then taken IFEQ.
        repeat (3) exec_one(1'b0);
        chk("cmp_status", 16'(status_reg), 16'h000C);
        chk("cmp_pc", 16'(pc), 16'd3);
        exec_one(1'b0);
        chk("ifeq_taken_pc", 16'(pc), 16'h0040);
        repeat (3) exec_one(1'b0);
        chk("add_carry", 16'(status_reg[0]), 16'd1);
        chk("add_zero", 16'(status_reg[2]), 16'd1);
        repeat (4) exec_one(1'b0);
        chk("ifz_not_taken_pc", 16'(pc), 16'h0047);
        exec_one(1'b0);
        exec_one(1'b0);
        chk("goto_pc", 16'(pc), 16'h00FF);
        exec_one(1'b0);
        chk("wrap_pc", 16'(pc), 16'h0000);

        // Drop run mid-instruction: it completes, then the sequencer holds.
        exec_one(1'b1);
        repeat (4) begin
            @(negedge clock);
            chk("hold_state", 16'(state), 16'd0);
            chk("hold_pc", 16'(pc), 16'd1);
        end

`ifdef SEQ_STEP_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        run = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("step_wait_state", 16'(state), 16'd0);
        end
        repeat (3) begin
            exec_one(1'b0);
            step = 1'b0;
            @(negedge clock);
            chk("step_gap_state", 16'(state), 16'd0);
        end
        chk("step_pc", 16'(pc), 16'd3);
        step_keep = 1'b1;
        exec_one(1'b0);
        repeat (6) begin
            @(negedge clock);
            chk("step_held_state", 16'(state), 16'd0);
            chk("step_held_pc", 16'(pc), 16'h0040);
        end
        step = 1'b0;
        step_keep = 1'b0;
        @(negedge clock);
`endif

        // Random program, VAL/CMP biased so flags and registers get exercised.
        for (int a = 0; a < 256; a++) begin
            logic [15:0] rw;
            rw = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rw[15:11] = 5'($urandom_range(9, 10));
            imem[a] = rw;
        end
        repeat (200) begin
            bit drop;
            drop = ($urandom_range(0, 7) == 0);
            exec_one(drop);
            if (drop) begin
                @(negedge clock);
                chk("rand_hold_state", 16'(state), 16'd0);
                chk("rand_hold_pc", 16'(pc), 16'(m_pc));
            end
`ifdef SEQ_STEP_EN
            step = 1'b0;
            @(negedge clock);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
